score_display_bcd: RTL
======================

Name: score_display_bcd

Overview:
- Parametrised score accumulator with a sequential binary-to-BCD converter (shift-and-add-3, one bit per cycle) driving NUM_DIGITS seven-segment digits.
- Replaces the fixed 2-digit combinational divide/modulo display with a multi-digit, saturating, glitch-free registered display.
- Sits between the game-logic score events (coin, stomp, clear) and the board 7-seg pins.

Parameters:
- SCORE_W, 10, width of the binary score register.
- NUM_DIGITS, 3, number of decimal digits displayed.
- MAX_SCORE, 999, saturation ceiling. Must satisfy MAX_SCORE < 10**NUM_DIGITS and MAX_SCORE < 2**SCORE_W; elaboration fails otherwise.
- BLANK_LEAD, 1, 1 = blank leading zeros (digit 0 is never blanked), 0 = show all zeros.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- add_en  input  1  add add_val to score this cycle.
- add_val  input  8  unsigned increment.
- clear  input  1  synchronous score clear; priority over add_en.
- score  output  SCORE_W  current binary score, registered.
- seg_out  output  7*NUM_DIGITS  active-low segments; digit i occupies bits [7i+6:7i]; digit 0 is the ones digit.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when seg_out has just updated.

Behaviour:
- Reset (async, active-high) sets: score=0, dirty=0, state=IDLE, busy=0, done=0.
  - With BLANK_LEAD=1: digit 0 = 7'b1000000, all other digits = 7'b1111111.
  - With BLANK_LEAD=0: every digit = 7'b1000000.
- Score register, evaluated at each clk edge:
  - clear=1: score <= 0.
  - else add_en=1: score <= min(score+add_val, MAX_SCORE). The sum is computed in max(SCORE_W,8)+1 bits, so it never wraps.
  - Either event sets dirty=1, including a zero add or an already-saturated add.
- FSM states are IDLE, SHIFT and LATCH.
  - IDLE & dirty: capture score into the shift register, clear the BCD register (4*NUM_DIGITS bits), clear dirty, bit count=0, go to SHIFT, busy=1.
  - SHIFT: each cycle, first add 3 to every BCD nibble ≥5, then shift {bcd,bin} left by 1. After SCORE_W shifts go to LATCH.
  - LATCH: encode every nibble and register it into seg_out, pulse done=1, busy=0, go to IDLE.
- Latency: add_en sampled at edge k → score valid after k; capture at k+1; shifts at k+2..k+1+SCORE_W; seg_out and done at k+2+SCORE_W. That is SCORE_W+2 cycles (12 at default).
- Events arriving during SHIFT/LATCH update score and set dirty only. The running conversion completes with its captured value, then IDLE immediately restarts. No event is lost, and seg_out always shows a fully converted value (no intermediate glitch).
- Simultaneous clear and dirty-clearing capture in the same edge: the capture takes the old score, and dirty is set again by the clear. The new-event set always wins over the capture clear.
- Leading-zero blanking (BLANK_LEAD=1): digit i>0 is blanked iff it and all higher digits are 0.
- Segment table (gfedcba, active low):
  - 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001
  - 5 0010010, 6 0000010, 7 1011000, 8 0000000, 9 0010000
  - blank 1111111
  - Nibble values >9 cannot occur; they encode as blank.
- Reset asserted mid-conversion: immediate return to the reset state; no done pulse.

Decomposition:
- Package score_pkg holds:
  - SEG_0..SEG_9 and SEG_BLANK constants.
  - State encodings IDLE/SHIFT/LATCH.
  - A function clog2 for the bit-counter width.
- Sub-module seg7_encode: combinational, 4-bit nibble + blank flag → 7-bit pattern. It is instantiated NUM_DIGITS times in a generate loop.
- The top holds the score register, dirty flag, FSM, shift/BCD registers and the blanking chain.

Test Plan:
- Reset release → score=0, seg_out digits {blank,blank,1000000}, busy=0, done=0. Same check with BLANK_LEAD=0 → all three digits 1000000.
- add_en=1, add_val=57 for one cycle → busy for 11 cycles, done exactly 12 cycles after the add edge. seg_out = {blank,0010010,1011000}, score=57.
- From score=990, add_val=200 → score=999 (saturated), digits 0010000 ×3.
- Three adds of 1 on consecutive cycles starting mid-conversion → done pulses twice in total. Final display is 3, and no intermediate nibble pattern appears on seg_out between done pulses.
- clear and add_en=1 (add_val=5) in the same cycle at score=42 → score=0, final display {blank,blank,1000000}.
- Reset asserted at shift 5 of a conversion of 123 → all outputs at reset values immediately. No done pulse, FSM in IDLE after release, dirty=0.

Source files
------------

// File: rtl/score_pkg.sv
// Shared constants for the score display: segment patterns, converter states
// and a constant-width helper used to size the shift counter.
package score_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1011000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_t;

    // Ceiling log2; a value of 1 returns 0, so callers size counters with n+1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/score_display_bcd_seg7_encode.sv
// Combinational nibble to active-low seven-segment pattern (gfedcba).
// Any nibble above 9, or an asserted blank flag, turns the digit off.
module seg7_encode
    import score_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (!blank) begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/score_display_bcd.sv
// Saturating score accumulator feeding a one-bit-per-cycle shift-and-add-3
// BCD converter; the segment outputs only change once a conversion completes.
module score_display_bcd
    import score_pkg::*;
#(
    parameter int SCORE_W    = 10,
    parameter int NUM_DIGITS = 3,
    parameter int MAX_SCORE  = 999,
    parameter bit BLANK_LEAD = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    add_en,
    input  logic [7:0]              add_val,
    input  logic                    clear,
    output logic [SCORE_W-1:0]      score,
    output logic [7*NUM_DIGITS-1:0] seg_out,
    output logic                    busy,
    output logic                    done
);

    localparam int SUM_W = ((SCORE_W > 8) ? SCORE_W : 8) + 1;
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int SEG_W = 7 * NUM_DIGITS;
    localparam int CNT_W = clog2(SCORE_W + 1);

    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(SCORE_W - 1);
    localparam logic [SUM_W-1:0] MAX_SUM    = SUM_W'(MAX_SCORE);

    localparam longint DIGIT_LIMIT = longint'(10) ** NUM_DIGITS;
    localparam longint SCORE_LIMIT = longint'(1) << SCORE_W;

    if ((longint'(MAX_SCORE) >= DIGIT_LIMIT) || (longint'(MAX_SCORE) >= SCORE_LIMIT)) begin : g_bad_params
        $error("score_display_bcd: MAX_SCORE must fit both NUM_DIGITS digits and SCORE_W bits");
    end

    function automatic logic [SEG_W-1:0] reset_pattern();
        logic [SEG_W-1:0] p;
        p = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            p[7*d +: 7] = ((d == 0) || !BLANK_LEAD) ? SEG_0 : SEG_BLANK;
        end
        return p;
    endfunction

    localparam logic [SEG_W-1:0] SEG_RESET = reset_pattern();

    state_t                  state;
    state_t                  state_nxt;
    logic                    dirty;
    logic                    event_hit;
    logic                    capture;
    logic [SUM_W-1:0]        sum;
    logic [SCORE_W-1:0]      next_score;
    logic [CNT_W-1:0]        bit_cnt;
    logic [SCORE_W-1:0]      bin_sr;
    logic [BCD_W-1:0]        bcd_sr;
    logic [BCD_W-1:0]        bcd_adj;
    logic [NUM_DIGITS-1:0]   blank;
    logic                    zero_above;
    logic [SEG_W-1:0]        seg_enc;

    assign event_hit = clear | add_en;
    assign capture   = (state == IDLE) && dirty;
    assign busy      = (state != IDLE);

    // Wide enough sum that the saturation compare never sees a wrapped value.
    always_comb begin
        sum        = SUM_W'(score) + SUM_W'(add_val);
        next_score = (sum > MAX_SUM) ? SCORE_W'(MAX_SCORE) : sum[SCORE_W-1:0];
    end

    // A new event always re-arms dirty, even on the edge that captures.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            score <= '0;
            dirty <= 1'b0;
        end else begin
            if (clear) begin
                score <= '0;
            end else if (add_en) begin
                score <= next_score;
            end
            if (event_hit) begin
                dirty <= 1'b1;
            end else if (capture) begin
                dirty <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (dirty) state_nxt = SHIFT;
            SHIFT:   if (bit_cnt == LAST_SHIFT) state_nxt = LATCH;
            LATCH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bcd_adj = bcd_sr;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (bcd_sr[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd_sr[4*d +: 4] + 4'd3;
            end
        end
    end

    // Converter datapath: {bcd, bin} shifts left once per SHIFT cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin_sr  <= '0;
            bcd_sr  <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dirty) begin
                        bin_sr  <= score;
                        bcd_sr  <= '0;
                        bit_cnt <= '0;
                    end
                end
                SHIFT: begin
                    bcd_sr  <= {bcd_adj[BCD_W-2:0], bin_sr[SCORE_W-1]};
                    bin_sr  <= {bin_sr[SCORE_W-2:0], 1'b0};
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    // A digit is blank only while it and every digit above it are zero.
    always_comb begin
        blank      = '0;
        zero_above = 1'b1;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            zero_above = zero_above && (bcd_sr[4*d +: 4] == 4'd0);
            blank[d]   = BLANK_LEAD && zero_above;
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        seg7_encode u_enc (
            .nibble (bcd_sr[4*i +: 4]),
            .blank  (blank[i]),
            .seg    (seg_enc[7*i +: 7])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_out <= SEG_RESET;
            done    <= 1'b0;
        end else begin
            done <= (state == LATCH);
            if (state == LATCH) begin
                seg_out <= seg_enc;
            end
        end
    end

endmodule
